// File: rtl/read_empty.sv
// Read-side pointer and empty-flag controller for an async FIFO.
// Tracks the read binary/Gray pointer and derives empty, almost-empty, occupancy, read-valid and underflow.
module read_empty #(
    parameter int ADDRESS_SIZE        = 4,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    rinc,
    input  logic                    uf_clear,
    input  logic [ADDRESS_SIZE:0]   rq2_write_ptr,
    output logic [ADDRESS_SIZE-1:0] raddr,
    output logic [ADDRESS_SIZE:0]   rptr,
    output logic                    rempty,
    output logic                    ralmost_empty,
    output logic [ADDRESS_SIZE:0]   rcount,
    output logic                    rvalid,
    output logic                    runderflow
);

    localparam logic [ADDRESS_SIZE:0] THRESH = (ADDRESS_SIZE + 1)'(ALMOST_EMPTY_THRESH);

    logic [ADDRESS_SIZE:0] rbin;
    logic [ADDRESS_SIZE:0] rbinnext;
    logic [ADDRESS_SIZE:0] rgraynext;
    logic [ADDRESS_SIZE:0] wbin_s;
    logic [ADDRESS_SIZE:0] occ_next;
    logic                  pop;

    assign pop       = rinc & ~rempty;
    assign rbinnext  = rbin + (ADDRESS_SIZE + 1)'(pop);
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;
    assign raddr     = rbin[ADDRESS_SIZE-1:0];

    // Gray-to-binary: each bit is the XOR of itself and all higher bits.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= ADDRESS_SIZE; i++) begin
            wbin_s[i] = ^(rq2_write_ptr >> i);
        end
    end

    assign occ_next = wbin_s - rbinnext;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rcount        <= '0;
            rvalid        <= 1'b0;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbinnext;
            rptr          <= rgraynext;
            // Compared against the next pointer so the last pop raises empty on the same edge.
            rempty        <= (rgraynext == rq2_write_ptr);
            ralmost_empty <= (occ_next <= THRESH);
            rcount        <= occ_next;
            rvalid        <= pop;
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end else if (uf_clear) begin
                runderflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/read_empty.md
Name: read_empty

Overview:
- Read-side pointer and empty-flag controller for the async FIFO. It is the read-domain counterpart of the write-full logic.
- Owns the read binary/Gray pointer and drives the FIFO memory read address.
- Compares its own pointer against the write pointer that has already been synchronized into the read clock domain. From that it produces a registered empty flag, an almost-empty flag, an occupancy count, a read-valid strobe and a sticky underflow error.
- Its Gray pointer output feeds the synchronizer back into the write domain.

Parameters:
- ADDRESS_SIZE, 4: memory address width; FIFO depth = 2**ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits.
- ALMOST_EMPTY_THRESH, 2: ralmost_empty is asserted when occupancy is at or below this value; legal range 0..2**ADDRESS_SIZE.

Ports:
- rclk  input  1  read-domain clock; all state updates on its rising edge.
- rrst  input  1  asynchronous, active-high reset.
- rinc  input  1  read request; pops one entry when rempty=0.
- uf_clear  input  1  synchronous clear of runderflow.
- rq2_write_ptr  input  ADDRESS_SIZE+1  write pointer, Gray-coded, already 2-flop synchronized into rclk.
- raddr  output  ADDRESS_SIZE  memory read address.
- rptr  output  ADDRESS_SIZE+1  registered Gray read pointer, to the write-domain synchronizer.
- rempty  output  1  registered FIFO-empty flag.
- ralmost_empty  output  1  registered almost-empty flag.
- rcount  output  ADDRESS_SIZE+1  registered occupancy, 0..2**ADDRESS_SIZE.
- rvalid  output  1  one-cycle strobe: the memory data at the popped address is valid.
- runderflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rrst=1, asynchronous, effective immediately regardless of rclk):
  - rbin=0, rptr=0, rcount=0, rvalid=0, runderflow=0.
  - rempty=1, ralmost_empty=1.
  - Same values when reset is asserted mid-operation; no partial pop survives.
- Pop: pop = rinc & ~rempty. rbinnext = rbin + pop, wrapping modulo 2**(ADDRESS_SIZE+1).
- raddr = rbin[ADDRESS_SIZE-1:0], driven directly from the register (no added latency). The popped entry's address is presented in the cycle the pop is accepted.
- Gray code: rgraynext = (rbinnext>>1) ^ rbinnext. rptr <= rgraynext each edge. Successive rptr values differ in exactly 1 bit, including at the wrap 2**(ADDRESS_SIZE+1)-1 -> 0.
- Empty: rempty <= (rgraynext == rq2_write_ptr). Evaluated against the next pointer, so rempty rises on the same edge that pops the last entry (no extra read allowed).
- Occupancy:
  - wbin_s = Gray-to-binary of rq2_write_ptr (bit i = XOR of bits ADDRESS_SIZE..i).
  - rcount <= (wbin_s - rbinnext) mod 2**(ADDRESS_SIZE+1).
  - ralmost_empty <= (that same value <= ALMOST_EMPTY_THRESH).
  - rempty and rcount==0 always agree in the same cycle.
- rvalid <= pop. Asserts one cycle after the accepted pop, matching a registered-output memory. Back-to-back pops give rvalid high on consecutive cycles.
- Underflow:
  - rinc=1 while rempty=1: no pointer change; runderflow <= 1 on that edge.
  - runderflow stays set until uf_clear=1 or reset.
  - If set and clear occur in the same cycle, set wins.
- rq2_write_ptr may advance by any amount between cycles. Flags are conservative (pessimistic empty) because the write pointer is delayed by the synchronizer; this is not an error.
- Simultaneous pop and write-pointer advance: all outputs follow the equations above from the new rbinnext and the current rq2_write_ptr; no priority logic is needed.

Test Plan (ADDRESS_SIZE=4, ALMOST_EMPTY_THRESH=2):
- Reset release, rq2_write_ptr=0, rinc=0 -> rempty=1, ralmost_empty=1, rcount=0, rptr=00000, raddr=0, rvalid=0.
- rq2_write_ptr=00010 (Gray of 3) -> next edge rempty=0, rcount=3, ralmost_empty=0. Then 3 consecutive rinc:
  - raddr = 0, 1, 2.
  - rptr = 00001, 00011, 00010.
  - rcount = 2, 1, 0; ralmost_empty=1 from the first pop.
  - rempty=1 on the third pop edge.
  - rvalid high for 3 cycles, delayed one cycle.
- rinc=1 while empty -> rbin/raddr unchanged, runderflow=1 next edge and held. Assert uf_clear together with another empty rinc -> runderflow stays 1. uf_clear alone -> runderflow=0.
- rq2_write_ptr=11000 (Gray of 16) with rbin=0 -> rcount=16, rempty=0, ralmost_empty=0.
- Wrap: step write and read pointers past 31:
  - rptr goes 10000 -> 00000 (single-bit change).
  - raddr goes 15 -> 0.
  - rcount stays correct across the wrap.
- Assert rrst between edges mid-stream with rcount=5 -> outputs return to reset values immediately, without waiting for rclk. After release, reads resume from raddr=0.
